// File: rtl/mul_sequencer_if.sv
// Bundle between the EX stage and the multi-cycle multiply sequencer.
// master = pipeline side, slave = sequencer side.
interface mul_sequencer_if #(
    parameter int DATA_W = 64
);
    logic              start;
    logic              flush;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic              op_high;
    logic              stall;
    logic              busy;
    logic [DATA_W-1:0] result;
    logic              result_valid;

    modport master (
        output start, flush, operand_a, operand_b, op_high,
        input  stall, busy, result, result_valid
    );

    modport slave (
        input  start, flush, operand_a, operand_b, op_high,
        output stall, busy, result, result_valid
    );
endinterface

// File: rtl/mul_sequencer.sv
// Multi-cycle shift-add MUL sequencer for EX; stalls the pipeline for N+1 cycles.
// Optional MUL_HIGH_EN: 2*DATA_W accumulator and signed MULH high-half result.
module mul_sequencer #(
    parameter int DATA_W  = 64,
    parameter int CHUNK_W = 16
) (
    input  logic           clk,
    input  logic           arst,
    mul_sequencer_if.slave bus
);
    localparam int N     = DATA_W / CHUNK_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
`ifdef MUL_HIGH_EN
    localparam int ACC_W = 2 * DATA_W;
`else
    localparam int ACC_W = DATA_W;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_a_sh;
    logic [DATA_W-1:0]  r_b;
    logic [DATA_W-1:0]  r_result;

    logic               w_accept;
    logic               w_last;
    logic               w_stall;
    logic [ACC_W-1:0]   w_a_init;
    logic [DATA_W-1:0]  w_b_init;
    logic [ACC_W-1:0]   w_chunk;
    logic [ACC_W-1:0]   w_pp;
    logic [DATA_W-1:0]  w_res;

    assign w_accept = (r_state == S_IDLE) && bus.start && !bus.flush;
    assign w_last   = (r_cnt == CNT_W'(N - 1));

`ifdef MUL_HIGH_EN
    logic               r_high;
    logic               r_neg;
    logic               w_a_neg, w_b_neg;
    logic [DATA_W-1:0]  w_a_mag;
    logic [ACC_W-1:0]   w_prod;

    // MULH works on magnitudes; the sign is re-applied to the full product in DONE
    assign w_a_neg  = bus.op_high && bus.operand_a[DATA_W-1];
    assign w_b_neg  = bus.op_high && bus.operand_b[DATA_W-1];
    assign w_a_mag  = w_a_neg ? -bus.operand_a : bus.operand_a;
    assign w_b_init = w_b_neg ? -bus.operand_b : bus.operand_b;
    assign w_a_init = {{(ACC_W-DATA_W){1'b0}}, w_a_mag};
    assign w_prod   = (r_high && r_neg) ? -r_acc : r_acc;
    assign w_res    = r_high ? w_prod[ACC_W-1:DATA_W] : w_prod[DATA_W-1:0];
`else
    logic               w_unused_op_high;

    assign w_unused_op_high = bus.op_high;
    assign w_a_init         = bus.operand_a;
    assign w_b_init         = bus.operand_b;
    assign w_res            = r_acc;
`endif

    // Multiplicand is pre-shifted each cycle, so the chunk product lands at cnt*CHUNK_W
    assign w_chunk = ACC_W'(r_b[CHUNK_W-1:0]);
    assign w_pp    = r_a_sh * w_chunk;

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next  = S_RUN;
                    w_stall = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.flush) begin
                    w_next = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                    if (w_last) w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_a_sh   <= '0;
            r_b      <= '0;
            r_result <= '0;
`ifdef MUL_HIGH_EN
            r_high   <= 1'b0;
            r_neg    <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a_sh <= w_a_init;
                        r_b    <= w_b_init;
                        r_acc  <= '0;
                        r_cnt  <= '0;
`ifdef MUL_HIGH_EN
                        r_high <= bus.op_high;
                        r_neg  <= w_a_neg ^ w_b_neg;
`endif
                    end
                end
                S_RUN: begin
                    r_acc  <= r_acc + w_pp;
                    r_cnt  <= r_cnt + 1'b1;
                    r_a_sh <= r_a_sh << CHUNK_W;
                    r_b    <= r_b >> CHUNK_W;
                end
                S_DONE:  r_result <= w_res;
                default: ;
            endcase
        end
    end

    assign bus.stall        = w_stall;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.result_valid = (r_state == S_DONE);
    assign bus.result       = (r_state == S_DONE) ? w_res : r_result;
endmodule
